// File: rtl/datacache_sram_arbiter_if.sv
// Requester-side bundle shared by the core and refill ports of the data-cache SRAM arbiter.
// The master is the requester, the slave is the arbiter.
interface datacache_sram_arbiter_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NUM_WMASKS-1:0] wmask;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata, wmask,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wmask,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/datacache_sram_arbiter.sv
// Single-port data-cache SRAM arbiter: refill beats core by default, core gets forced priority
// after STARVE_LIMIT consecutive losses unless a refill burst holds the lock.
module datacache_sram_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_WMASKS   = 4,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  datacache_sram_arbiter_if.slave core,
  datacache_sram_arbiter_if.slave rf,
  input  logic                  rf_lock_i,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [NUM_WMASKS-1:0] sram_wmask_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam logic [7:0] LIMIT   = 8'(STARVE_LIMIT);
  localparam logic       PORT_RF = 1'b1;

  logic [7:0]              starve_q, starve_d;
  logic [READ_LATENCY:1]   vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY:1]   id_pipe_q, id_pipe_d;
  logic                    starved, core_win, rf_win, rd_issue;

  // Grants are masked while reset is held so nothing reaches the macro.
  always_comb begin
    starved  = (starve_q == LIMIT) && !rf_lock_i;
    core_win = rst_ni && core.req && (!rf.req || starved);
    rf_win   = rst_ni && rf.req && !core_win;
  end

  assign core.gnt = core_win;
  assign rf.gnt   = rf_win;

  always_comb begin
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (core_win) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = !core.we;
      sram_wmask_o = core.we ? core.wmask : '0;
      sram_addr_o  = core.addr;
      sram_wdata_o = core.we ? core.wdata : '0;
    end else if (rf_win) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = !rf.we;
      sram_wmask_o = rf.we ? rf.wmask : '0;
      sram_addr_o  = rf.addr;
      sram_wdata_o = rf.we ? rf.wdata : '0;
    end
  end

  // Counts consecutive core losses; any core grant or idle core restarts the count.
  always_comb begin
    starve_d = starve_q;
    if (!core.req || core_win)  starve_d = '0;
    else if (starve_q != LIMIT) starve_d = starve_q + 8'd1;
  end

  // Read tag pipe: slot 1 is loaded at the grant edge, slot READ_LATENCY lines up with rdata.
  always_comb begin
    rd_issue      = (core_win && !core.we) || (rf_win && !rf.we);
    vld_pipe_d    = vld_pipe_q;
    id_pipe_d     = id_pipe_q;
    vld_pipe_d[1] = rd_issue;
    id_pipe_d[1]  = rf_win;
    for (int i = 2; i <= READ_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      id_pipe_d[i]  = id_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q   <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
    end
  end

  always_comb begin
    rf.rvalid   = vld_pipe_q[READ_LATENCY] && (id_pipe_q[READ_LATENCY] == PORT_RF);
    core.rvalid = vld_pipe_q[READ_LATENCY] && (id_pipe_q[READ_LATENCY] != PORT_RF);
    rf.rdata    = rf.rvalid   ? sram_rdata_i : '0;
    core.rdata  = core.rvalid ? sram_rdata_i : '0;
  end

endmodule
